mesh_port_arbiter: RTL

Round-robin arbiter that shares one mesh router terminal input port among N_REQ local traffic sources. Each source offers packets on a valid/ready handshake. The arbiter latches the winning packet into a holding register and presents it to the router on the pndng/data/pop protocol. It sits between the traffic generators and one router edge port: its pndng_o/data_o drive that port's pndng_i_in/data_out_i_in, and the port's pop feeds pop_i.

---
 rtl/mesh_arb_pkg.sv | 44 ++++
 rtl/mesh_rr_pick.sv | 29 ++
 rtl/mesh_port_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/mesh_arb_pkg.sv
// Shared types and helpers for the mesh router port arbiter.
// rr_pick is a fixed-width round-robin scan; callers zero-extend into it.
package mesh_arb_pkg;

    localparam int unsigned MaxReq = 16;
    localparam int unsigned MaxIdW = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              any;
        logic [MaxIdW-1:0] idx;
    } rr_pick_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Scan valid from ptr upward, wrapping at n; first set bit wins.
    function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                         input logic [MaxIdW-1:0] ptr,
                                         input int unsigned       n);
        rr_pick_t          res;
        int unsigned       j;
        logic [MaxIdW-1:0] j4;
        res = '0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            if (k < n) begin
                j = 32'(ptr) + k;
                if (j >= n) j = j - n;
                j4 = MaxIdW'(j);
                if (!res.any && valid[j4]) begin
                    res.any = 1'b1;
                    res.idx = j4;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mesh_rr_pick.sv
// Combinational rotate/priority-encode picking the next round-robin winner.
module mesh_rr_pick
    import mesh_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IdW   = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IdW-1:0]   ptr_i,
    output logic             any_o,
    output logic [IdW-1:0]   idx_o
);

    logic [MaxReq-1:0] valid_ext;
    logic [MaxIdW-1:0] ptr_ext;
    rr_pick_t          pick;

    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = valid_i;
        ptr_ext                = '0;
        ptr_ext[IdW-1:0]       = ptr_i;
        pick                   = rr_pick(valid_ext, ptr_ext, N_REQ);
    end

    assign any_o = pick.any;
    assign idx_o = pick.idx[IdW-1:0];

endmodule

// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter feeding one mesh router input port through a single holding slot.
// The slot reloads on the same edge it is popped, so throughput is one packet per cycle.
module mesh_port_arbiter
    import mesh_arb_pkg::*;
#(
    parameter int unsigned PCKG_SZ = 32,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned IdW     = id_width(N_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ-1:0][PCKG_SZ-1:0]   req_data,
    output logic [N_REQ-1:0]                req_ready,
    output logic                            pndng_o,
    output logic [PCKG_SZ-1:0]              data_o,
    input  logic                            pop_i,
    output logic [IdW-1:0]                  grant_id,
    output logic                            busy,
    output logic                            timeout_err,
    output logic                            proto_err
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e         state_q, state_d;
    logic [PCKG_SZ-1:0] data_q, data_d;
    logic [IdW-1:0]     gid_q, gid_d;
    logic [IdW-1:0]     ptr_q, ptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               terr_q, terr_d;
    logic               perr_q, perr_d;

    logic               pick_any;
    logic [IdW-1:0]     pick_idx;
    logic               free;
    logic               accept;

    mesh_rr_pick #(
        .N_REQ (N_REQ),
        .IdW   (IdW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .any_o   (pick_any),
        .idx_o   (pick_idx)
    );

    assign free   = (state_q == ARB_IDLE) || pop_i;
    assign accept = free && pick_any && !reset;

    always_comb begin
        req_ready           = '0;
        if (accept) req_ready[pick_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        perr_d  = perr_q;
        if (state_q == ARB_IDLE && pop_i) perr_d = 1'b1;
        if (accept) begin
            state_d = ARB_HOLD;
            data_d  = req_data[pick_idx];
            gid_d   = pick_idx;
            ptr_d   = (pick_idx == IdW'(N_REQ - 1)) ? '0 : pick_idx + IdW'(1);
            cnt_d   = '0;
        end else if (state_q == ARB_HOLD) begin
            if (pop_i) begin
                state_d = ARB_IDLE;
            end else if (cnt_q != CntW'(TIMEOUT)) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        if (TIMEOUT != 0 && state_d == ARB_HOLD && cnt_d == CntW'(TIMEOUT)) terr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            data_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            perr_q  <= perr_d;
        end
    end

    assign pndng_o     = (state_q == ARB_HOLD);
    assign busy        = pndng_o;
    assign data_o      = data_q;
    assign grant_id    = gid_q;
    assign timeout_err = terr_q;
    assign proto_err   = perr_q;

endmodule
